fec_param_fifo: RTL

//  Parametrised synchronous FIFO, the successor to the fixed-width message FIFO of the FEC encoder.

---
 rtl/encoder_fec_pkg.sv | 20 ++
 rtl/fec_fifo_mem.sv | 26 ++
 rtl/fec_param_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/encoder_fec_pkg.sv
// Shared definitions for the FEC encoder: default FIFO sizing, the per-cycle
// FIFO operation encoding, and a helper for sizing level ports in parent modules.
package encoder_fec_pkg;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_WIDTH_DEF = 32;

    // Encoded as {write accepted, read accepted}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fec_fifo_mem.sv
// Storage array for the FEC FIFO: one synchronous write port, one asynchronous
// read port. Deliberately unreset so it maps onto distributed/block RAM.
module fec_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fec_param_fifo.sv
// Parametrised synchronous FIFO between the encoder front-end and the FEC datapath,
// with level count, threshold flags, sticky error flags, flush and optional FWFT read.
module fec_param_fifo
    import encoder_fec_pkg::*;
#(
    parameter int WIDTH         = FIFO_WIDTH_DEF,
    parameter int DEPTH         = FIFO_DEPTH_DEF,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = fifo_level_w(DEPTH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fec_param_fifo: DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH - 1)) begin : g_bad_afull
        $error("fec_param_fifo: AFULL_THRESH out of range 1..DEPTH-1");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
        $error("fec_param_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fec_param_fifo: WIDTH must be at least 1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic [WIDTH-1:0] mem_rdata;
    logic             rd_acc;
    logic             wr_acc;
    fifo_op_e         op;

    // A full FIFO still takes a write when a read frees a slot in the same cycle
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    fec_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            case (op)
                OP_WRITE: level_next = level + LW'(1);
                OP_READ:  level_next = level - LW'(1);
                default:  level_next = level;
            endcase
        end
    end

    // Flags are registered from level_next so they never lag the level output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            level        <= level_next;
            empty        <= (level_next == '0);
            full         <= (level_next == LW'(DEPTH));
            almost_full  <= (level_next >= LW'(AFULL_THRESH));
            almost_empty <= (level_next <= LW'(AEMPTY_THRESH));
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                overflow  <= overflow | (wr_en & ~wr_acc);
                underflow <= underflow | (rd_en & empty);
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Gate the head word so data_out reads zero whenever nothing is stored
        assign data_out = empty ? '0 : mem_rdata;
        assign rd_valid = ~empty;
    end else begin : g_registered
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out <= '0;
                rd_valid <= 1'b0;
            end else if (flush || !rd_acc) begin
                data_out <= '0;
                rd_valid <= 1'b0;
            end else begin
                data_out <= mem_rdata;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule
